core_sequencer: RTL

- Run-control block that sequences one execution of the 8-bit core: host preload of data memory, core reset release, run, completion/timeout, result readback.
- Owns the core's req (reset) line.
- Multiplexes the single dat_mem port between the host and the core.
- Sits between the bench/host and the core top level.

---
 rtl/core_sequencer_if.sv | 46 ++++
 rtl/core_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/core_sequencer_if.sv
// Host/core/memory bundle around the run-control sequencer.
// Pure wiring, no latency.
// host_ready is the only flow-control signal; there is no other backpressure.
interface core_sequencer_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // host side
  logic          start;
  logic          host_valid;
  logic          host_ready;
  logic          host_last;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  // core side
  logic          core_req;
  logic          core_done;
  logic          core_mem_wr;
  logic [AW-1:0] core_mem_addr;
  logic [DW-1:0] core_mem_din;
  // data memory port
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  // status
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [15:0]   run_cycles;

  // Host/bench view: drives requests and the core's outputs, observes the rest.
  modport master (
    output start, host_valid, host_last, host_addr, host_data,
    output core_done, core_mem_wr, core_mem_addr, core_mem_din,
    input  host_ready, core_req, mem_wr, mem_addr, mem_din,
    input  busy, finished, timeout, run_cycles
  );

  // Sequencer view.
  modport slave (
    input  start, host_valid, host_last, host_addr, host_data,
    input  core_done, core_mem_wr, core_mem_addr, core_mem_din,
    output host_ready, core_req, mem_wr, mem_addr, mem_din,
    output busy, finished, timeout, run_cycles
  );
endinterface

// File: rtl/core_sequencer.sv
// Run control for one core execution: preload, reset release, run, stop, readback.
// start->host_ready 1 cycle; last load accept->core_req low RST_CYC+1 cycles.
// Loads are never stalled: host_ready is high for the whole LOAD state.
module core_sequencer #(
  parameter int          D       = 12,
  parameter int          AW      = 8,
  parameter int          DW      = 8,
  parameter int          RST_CYC = 2,    // 1..256
  parameter int unsigned TIMEOUT = 4095
) (
  input logic            clk,
  input logic            reset_n,
  core_sequencer_if.slave bus
);

  // The cycle budget can never exceed what the core's program counter spans.
  localparam int unsigned PC_MAX = (1 << D) - 1;
  localparam int unsigned BUDGET = (TIMEOUT > PC_MAX) ? PC_MAX : TIMEOUT;
  localparam logic [15:0] BUDGET_C = 16'(BUDGET);
  localparam logic [7:0]  RST_LAST = 8'(RST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RSTC,
    S_RUN,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [AW:0] load_cnt_q, load_cnt_d;   // words written in the current load
  logic        finished_q, finished_d;
  logic        timeout_q, timeout_d;
  logic [15:0] run_cycles_q, run_cycles_d;
  logic [15:0] run_inc;

  logic          mem_wr_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] mem_din_c;

  // State and status registers; async reset parks the core in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      load_cnt_q   <= '0;
      finished_q   <= 1'b0;
      timeout_q    <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      load_cnt_q   <= load_cnt_d;
      finished_q   <= finished_d;
      timeout_q    <= timeout_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // Next-state logic. The RUN cycle that ends the run is itself counted.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    load_cnt_d   = load_cnt_q;
    finished_d   = finished_q;
    timeout_d    = timeout_q;
    run_cycles_d = run_cycles_q;
    run_inc      = (run_cycles_q == 16'hFFFF) ? run_cycles_q : run_cycles_q + 16'd1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d      = S_LOAD;
          load_cnt_d   = '0;
          finished_d   = 1'b0;
          timeout_d    = 1'b0;
          run_cycles_d = '0;
        end
      end
      S_LOAD: begin
        if (bus.host_valid) begin
          load_cnt_d = load_cnt_q + 1'b1;
          if (bus.host_last) begin
            state_d   = S_RSTC;
            rst_cnt_d = '0;
          end
        end
      end
      S_RSTC: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        run_cycles_d = run_inc;
        // Completion wins over a coincident budget expiry.
        if (bus.core_done) begin
          state_d    = S_DONE;
          finished_d = 1'b1;
        end else if (run_inc == BUDGET_C) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port owner: host in LOAD, core in RUN, read-only host path otherwise.
  always_comb begin
    mem_wr_c   = 1'b0;
    mem_addr_c = bus.host_addr;
    mem_din_c  = bus.host_data;
    case (state_q)
      S_LOAD: mem_wr_c = bus.host_valid;
      S_RUN: begin
        mem_wr_c   = bus.core_mem_wr;
        mem_addr_c = bus.core_mem_addr;
        mem_din_c  = bus.core_mem_din;
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from the registered state.
  assign bus.core_req   = (state_q != S_RUN);
  assign bus.host_ready = (state_q == S_LOAD);
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_RSTC) || (state_q == S_RUN);
  assign bus.finished   = finished_q;
  assign bus.timeout    = timeout_q;
  assign bus.run_cycles = run_cycles_q;
  assign bus.mem_wr     = mem_wr_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_din    = mem_din_c;

endmodule
